// File: rtl/cpu_bus_ctrl.sv
// rtl/cpu_bus_ctrl.sv - CPU bus decode: RAM, LED port, interval timer, ROM wait states
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high
//   AB        CPU address bus
//   DO        CPU write data
//   WE        CPU write enable
//   DI        registered read data returned to the CPU
//   RDY       combinational CPU ready (low while a ROM read waits)
//   IRQ       registered interrupt request (irq_flag & irq_en)
//   led       6-bit LED register at $4000
//   rom_addr  external ROM address (AB[14:0])
//   rom_data  external ROM data, valid ROM_WAIT cycles after rom_addr
//
// Build option: define CPU_BUS_CTRL_TIMER_EN to include the timer and its
// $4001-$4004 registers; otherwise those addresses read 8'hEA and IRQ is 0.

module cpu_bus_ctrl #(
  parameter int RAM_AW   = 11,
  parameter int ROM_WAIT = 1,
  parameter int TIMER_W  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] AB,
  input  logic [7:0]  DO,
  input  logic        WE,
  output logic [7:0]  DI,
  output logic        RDY,
  output logic        IRQ,
  output logic [5:0]  led,
  output logic [14:0] rom_addr,
  input  logic [7:0]  rom_data
);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  localparam logic [2:0] WAIT_LOAD = (ROM_WAIT > 0) ? 3'(ROM_WAIT - 1) : 3'd0;

  state_t     state, state_nx;
  logic [2:0] wcnt, wcnt_nx;
  logic       rom_rd, wr_en, rd_en;
  logic [7:0] rd_data;
  logic [7:0] ram [2**RAM_AW];

  assign rom_addr = AB[14:0];
  assign rom_rd   = AB[15] & ~WE;
  assign wr_en    = WE & RDY;
  // A read completes in any cycle where RDY is high; in S_WAIT that is the
  // final cycle, so the same path captures rom_data.
  assign rd_en    = RDY & ~WE;

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    RDY      = 1'b1;
    case (state)
      S_RUN: begin
        if (rom_rd && (ROM_WAIT > 0)) begin
          RDY      = 1'b0;
          wcnt_nx  = WAIT_LOAD;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wcnt != 3'd0) begin
          RDY     = 1'b0;
          wcnt_nx = wcnt - 3'd1;
        end else begin
          state_nx = S_RUN;
        end
      end
      default: state_nx = S_RUN;
    endcase
  end

`ifdef CPU_BUS_CTRL_TIMER_EN
  logic [1:0]         ctrl;      // bit0 run, bit1 irq_en
  logic [TIMER_W-1:0] reload;
  logic [TIMER_W-1:0] count;
  logic               irq_flag;
  logic               tick, stat_clr, ctrl_wr;

  assign ctrl_wr  = wr_en && (AB == 16'h4001);
  assign tick     = ctrl[0] && (count == '0);
  assign stat_clr = (AB == 16'h4004) && (rd_en || wr_en);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl     <= 2'b00;
      reload   <= '1;
      count    <= '1;
      irq_flag <= 1'b0;
      IRQ      <= 1'b0;
    end else begin
      if (ctrl_wr)                          ctrl         <= DO[1:0];
      if (wr_en && (AB == 16'h4002))        reload[7:0]  <= DO;
      if (wr_en && (AB == 16'h4003))        reload[15:8] <= DO;

      if (ctrl_wr)        count <= reload;
      else if (tick)      count <= reload;
      else if (ctrl[0])   count <= count - 1'b1;

      // Expiry beats a same-cycle status clear so no interrupt is lost.
      if (tick)           irq_flag <= 1'b1;
      else if (stat_clr)  irq_flag <= 1'b0;

      IRQ <= irq_flag & ctrl[1];
    end
  end
`else
  assign IRQ = 1'b0;
`endif

  always_comb begin
    rd_data = 8'hEA;
    if (AB[15])                rd_data = rom_data;
    else if (!AB[14])          rd_data = ram[AB[RAM_AW-1:0]];
    else if (AB == 16'h4000)   rd_data = {2'b00, led};
`ifdef CPU_BUS_CTRL_TIMER_EN
    else if (AB == 16'h4001)   rd_data = {6'b0, ctrl};
    else if (AB == 16'h4002)   rd_data = reload[7:0];
    else if (AB == 16'h4003)   rd_data = reload[15:8];
    else if (AB == 16'h4004)   rd_data = {irq_flag, 7'b0};
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RUN;
      wcnt  <= 3'd0;
      DI    <= 8'h00;
      led   <= 6'd0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
      if (rd_en) DI <= rd_data;
      if (wr_en && (AB == 16'h4000)) led <= DO[5:0];
    end
  end

  // RAM is mirrored across $0000-$3FFF and is not reset.
  always_ff @(posedge clk) begin
    if (wr_en && !AB[15] && !AB[14]) ram[AB[RAM_AW-1:0]] <= DO;
  end

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// tb/tb_cpu_bus_ctrl.sv - directed bench for cpu_bus_ctrl (ROM_WAIT=1 and ROM_WAIT=3 instances)

module tb_cpu_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset, reset3;
  logic [15:0] AB;
  logic [7:0]  DO;
  logic        WE;
  logic [7:0]  rom_data;

  logic [7:0]  DI, DI3;
  logic        RDY, RDY3, IRQ, IRQ3;
  logic [5:0]  led, led3;
  logic [14:0] rom_addr, rom_addr3;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  cpu_bus_ctrl #(.RAM_AW(11), .ROM_WAIT(1), .TIMER_W(16)) dut (
    .clk(clk), .reset(reset), .AB(AB), .DO(DO), .WE(WE),
    .DI(DI), .RDY(RDY), .IRQ(IRQ), .led(led),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  cpu_bus_ctrl #(.RAM_AW(11), .ROM_WAIT(3), .TIMER_W(16)) dut3 (
    .clk(clk), .reset(reset3), .AB(AB), .DO(DO), .WE(WE),
    .DI(DI3), .RDY(RDY3), .IRQ(IRQ3), .led(led3),
    .rom_addr(rom_addr3), .rom_data(rom_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; reset3 = 1'b1;
    AB = 16'h0000; DO = 8'h00; WE = 1'b0; rom_data = 8'h00;
    step(); step();
    checks++; if (DI !== 8'h00) $display("FAIL reset_DI: got %h expected 00", DI); else passed++;
    checks++; if (led !== 6'h00) $display("FAIL reset_led: got %h expected 00", led); else passed++;
    checks++; if (IRQ !== 1'b0) $display("FAIL reset_IRQ: got %b expected 0", IRQ); else passed++;
    checks++; if (RDY !== 1'b1) $display("FAIL reset_RDY: got %b expected 1", RDY); else passed++;
    checks++; if (led3 !== 6'h00 || IRQ3 !== 1'b0) $display("FAIL reset_dut3: got led=%h IRQ=%b expected 00/0", led3, IRQ3); else passed++;
    reset = 1'b0; reset3 = 1'b0;
    step();
  endtask

  task automatic test_reset_vector();
    AB = 16'hFFFC; WE = 1'b0; rom_data = 8'h00;
    #1;
    checks++; if (rom_addr !== 15'h7FFC) $display("FAIL vec_rom_addr: got %h expected 7ffc", rom_addr); else passed++;
    checks++; if (RDY !== 1'b0) $display("FAIL vec_lo_wait: got RDY=%b expected 0", RDY); else passed++;
    step();
    checks++; if (RDY !== 1'b1) $display("FAIL vec_lo_done: got RDY=%b expected 1", RDY); else passed++;
    step();
    checks++; if (DI !== 8'h00) $display("FAIL vec_lo_DI: got %h expected 00", DI); else passed++;
    AB = 16'hFFFD; rom_data = 8'hAA;
    #1;
    checks++; if (RDY !== 1'b0) $display("FAIL vec_hi_wait: got RDY=%b expected 0", RDY); else passed++;
    checks++; if (DI !== 8'h00) $display("FAIL vec_hi_hold: got DI=%h expected 00", DI); else passed++;
    step();
    checks++; if (RDY !== 1'b1) $display("FAIL vec_hi_done: got RDY=%b expected 1", RDY); else passed++;
    step();
    checks++; if (DI !== 8'hAA) $display("FAIL vec_hi_DI: got %h expected aa", DI); else passed++;
    AB = 16'h5000;
    step(); step(); step(); step();
  endtask

  task automatic test_led();
    AB = 16'h4000; DO = 8'h2A; WE = 1'b1;
    step();
    checks++; if (led !== 6'h2A) $display("FAIL led_write: got %h expected 2a", led); else passed++;
    WE = 1'b0;
    step();
    checks++; if (DI !== 8'h2A) $display("FAIL led_read: got %h expected 2a", DI); else passed++;
    DO = 8'hD5; WE = 1'b1;
    step();
    checks++; if (led !== 6'h15) $display("FAIL led_write_mask: got %h expected 15", led); else passed++;
    WE = 1'b0;
    step();
    checks++; if (DI !== 8'h15) $display("FAIL led_read_mask: got %h expected 15", DI); else passed++;
  endtask

  task automatic test_ram();
    WE = 1'b1;
    AB = 16'h0123; DO = 8'h5A; step();
    AB = 16'h07FF; DO = 8'hC3; step();
    AB = 16'h8000; DO = 8'h11;
    #1;
    checks++; if (RDY !== 1'b1) $display("FAIL rom_write_nowait: got RDY=%b expected 1", RDY); else passed++;
    step();
    WE = 1'b0;
    AB = 16'h0123; step();
    checks++; if (DI !== 8'h5A) $display("FAIL ram_read: got %h expected 5a", DI); else passed++;
    AB = 16'h0923; step();
    checks++; if (DI !== 8'h5A) $display("FAIL ram_mirror: got %h expected 5a", DI); else passed++;
    AB = 16'h3FFF; step();
    checks++; if (DI !== 8'hC3) $display("FAIL ram_mirror_top: got %h expected c3", DI); else passed++;
    AB = 16'h5000; step();
    checks++; if (DI !== 8'hEA) $display("FAIL unmapped_5000: got %h expected ea", DI); else passed++;
    AB = 16'h4005; step();
    checks++; if (DI !== 8'hEA) $display("FAIL unmapped_4005: got %h expected ea", DI); else passed++;
  endtask

`ifdef CPU_BUS_CTRL_TIMER_EN
  task automatic test_timer();
    WE = 1'b1;
    AB = 16'h4002; DO = 8'h03; step();
    AB = 16'h4003; DO = 8'h00; step();
    WE = 1'b0;
    AB = 16'h4002; step();
    checks++; if (DI !== 8'h03) $display("FAIL reload_lo_read: got %h expected 03", DI); else passed++;
    AB = 16'h4001; DO = 8'h03; WE = 1'b1;
    step();                                   // E0: count=3, run+irq_en
    AB = 16'h0123; WE = 1'b0;
    step(); step(); step(); step();           // E4: expiry sets irq_flag
    checks++; if (IRQ !== 1'b0) $display("FAIL irq_early: got %b expected 0", IRQ); else passed++;
    step();                                   // E5
    checks++; if (IRQ !== 1'b1) $display("FAIL irq_rise: got %b expected 1", IRQ); else passed++;
    AB = 16'h4004;
    step();                                   // E6: status read clears flag
    checks++; if (DI !== 8'h80) $display("FAIL status_read: got %h expected 80", DI); else passed++;
    AB = 16'h0123;
    step();                                   // E7
    checks++; if (IRQ !== 1'b0) $display("FAIL irq_drop: got %b expected 0", IRQ); else passed++;
    AB = 16'h4004;
    step();                                   // E8: expiry and read together
    checks++; if (DI !== 8'h00) $display("FAIL status_pre_set: got %h expected 00", DI); else passed++;
    AB = 16'h0123;
    step();                                   // E9
    checks++; if (IRQ !== 1'b1) $display("FAIL set_wins: got IRQ=%b expected 1", IRQ); else passed++;
    AB = 16'h4004;
    step();                                   // E10
    checks++; if (DI !== 8'h80) $display("FAIL status_after_set: got %h expected 80", DI); else passed++;
    AB = 16'h0123;
    step(); step();                           // E12: next expiry
    AB = 16'h4004; DO = 8'h00; WE = 1'b1;
    step();                                   // E13: write clears flag
    checks++; if (IRQ !== 1'b1) $display("FAIL irq_e13: got %b expected 1", IRQ); else passed++;
    AB = 16'h0123; WE = 1'b0;
    step();                                   // E14
    checks++; if (IRQ !== 1'b0) $display("FAIL write_clear: got %b expected 0", IRQ); else passed++;
    AB = 16'h4001; DO = 8'h00; WE = 1'b1; step();
    WE = 1'b0; AB = 16'h5000; step();
  endtask
`else
  task automatic test_timer();
    WE = 1'b1;
    AB = 16'h4002; DO = 8'h03; step();
    AB = 16'h4003; DO = 8'h00; step();
    AB = 16'h4001; DO = 8'h03; step();
    WE = 1'b0; AB = 16'h0123;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (IRQ !== 1'b0) $display("FAIL irq_absent_%0d: got %b expected 0", i, IRQ); else passed++;
    end
    AB = 16'h4004; step();
    checks++; if (DI !== 8'hEA) $display("FAIL status_absent: got %h expected ea", DI); else passed++;
    AB = 16'h4001; step();
    checks++; if (DI !== 8'hEA) $display("FAIL ctrl_absent: got %h expected ea", DI); else passed++;
    AB = 16'h5000; step();
  endtask
`endif

  task automatic test_reset_midwait();
    int low;
    AB = 16'h5000; WE = 1'b0;
    step(); step(); step(); step(); step();
    AB = 16'hFFFC; rom_data = 8'h55;
    #1;
    checks++; if (RDY3 !== 1'b0) $display("FAIL mid_wait1: got RDY=%b expected 0", RDY3); else passed++;
    step();                                   // second wait cycle
    checks++; if (RDY3 !== 1'b0) $display("FAIL mid_wait2: got RDY=%b expected 0", RDY3); else passed++;
    reset3 = 1'b1; AB = 16'h5000;
    #1;
    checks++; if (RDY3 !== 1'b1) $display("FAIL mid_rst_RDY: got %b expected 1", RDY3); else passed++;
    checks++; if (DI3 !== 8'h00) $display("FAIL mid_rst_DI: got %h expected 00", DI3); else passed++;
    step();
    checks++; if (DI3 !== 8'h00) $display("FAIL mid_rst_hold: got %h expected 00", DI3); else passed++;
    reset3 = 1'b0;
    AB = 16'hFFFD; rom_data = 8'h77;
    low = 0;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (RDY3 !== 1'b0) break;
      low++;
      step();
    end
    checks++; if (low !== 3) $display("FAIL mid_fresh_waits: got %0d expected 3", low); else passed++;
    step();
    checks++; if (DI3 !== 8'h77) $display("FAIL mid_fresh_DI: got %h expected 77", DI3); else passed++;
    checks++; if (rom_addr3 !== 15'h7FFD) $display("FAIL mid_rom_addr: got %h expected 7ffd", rom_addr3); else passed++;
    AB = 16'h5000;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_reset_vector();
    test_led();
    test_ram();
    test_timer();
    test_reset_midwait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
